// File: rtl/edge_fetch_sequencer.sv
// Source-edge fetch sequencer: walks one vertex's edge list, issues credit-limited
// reads and turns the in-order responses into per-edge tokens for downstream stages.
module edge_fetch_sequencer #(
  parameter int unsigned EDGE_BYTES      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        vtx_valid,
  output logic        vtx_ready,
  input  logic [63:0] vtx_id,
  input  logic [63:0] vtx_edge_addr,
  input  logic [63:0] vtx_num_edges,
  input  logic        vtx_last,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,

  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_edge_data,
  input  logic [63:0] mem_resp_dst_id,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_vertex_id,
  output logic [63:0] out_edge_id,
  output logic [63:0] out_dst_id,
  output logic [63:0] out_edge_data,
  output logic        out_last_edge,
  output logic        out_last_vertex,

  output logic        edges_empty,
  output logic        busy,
  output logic        err
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [63:0] vid_q, vid_d;
  logic [63:0] base_q, base_d;
  logic [63:0] num_q, num_d;
  logic        last_q, last_d;
  logic [63:0] issue_idx_q, issue_idx_d;
  logic [63:0] emit_idx_q, emit_idx_d;

  logic [CNT_W-1:0] credits_q, credits_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic edges_empty_q, edges_empty_d;
  logic err_q, err_d;

  logic [127:0] fifo_mem [MAX_OUTSTANDING];
  logic [127:0] head;

  logic accept;
  logic accept_edges;
  logic req_fire;
  logic pop;
  logic push;
  logic awaiting;
  logic spurious;
  logic last_issue;
  logic last_emit;

  assign accept       = vtx_valid & vtx_ready;
  assign accept_edges = accept & (vtx_num_edges != 64'd0);
  assign req_fire     = mem_req_valid & mem_req_ready;
  assign pop          = out_valid & out_ready;

  // Credits count in-flight requests plus buffered entries, so any surplus of
  // credits over buffered entries is exactly the requests still awaiting data.
  assign awaiting     = (credits_q != fifo_cnt_q);
  assign push         = mem_resp_valid & awaiting;
  assign spurious     = mem_resp_valid & ~awaiting;

  assign last_issue   = (issue_idx_q == (num_q - 64'd1));
  assign last_emit    = (emit_idx_q == (num_q - 64'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_edges) state_d = ISSUE;
      ISSUE:   if (req_fire && last_issue) state_d = DRAIN;
      DRAIN:   if (pop && last_emit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating ready with the reset pin keeps it low for the whole reset window.
  always_comb begin
    vtx_ready     = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE:    vtx_ready = reset;
      ISSUE:   mem_req_valid = (credits_q < CREDIT_MAX);
      default: ;
    endcase
  end

  always_comb begin
    vid_d       = vid_q;
    base_d      = base_q;
    num_d       = num_q;
    last_d      = last_q;
    issue_idx_d = issue_idx_q;
    emit_idx_d  = emit_idx_q;
    if (accept_edges) begin
      vid_d       = vtx_id;
      base_d      = vtx_edge_addr;
      num_d       = vtx_num_edges;
      last_d      = vtx_last;
      issue_idx_d = 64'd0;
      emit_idx_d  = 64'd0;
    end else begin
      if (req_fire) issue_idx_d = issue_idx_q + 64'd1;
      if (pop)      emit_idx_d  = emit_idx_q + 64'd1;
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({req_fire, pop})
      2'b10:   credits_d = credits_q + CNT_W'(1);
      2'b01:   credits_d = credits_q - CNT_W'(1);
      default: ;
    endcase
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: ;
    endcase
    wr_ptr_d      = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d      = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    edges_empty_d = accept & (vtx_num_edges == 64'd0);
    err_d         = err_q | spurious;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_q         <= 64'd0;
      base_q        <= 64'd0;
      num_q         <= 64'd0;
      last_q        <= 1'b0;
      issue_idx_q   <= 64'd0;
      emit_idx_q    <= 64'd0;
      credits_q     <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      edges_empty_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      vid_q         <= vid_d;
      base_q        <= base_d;
      num_q         <= num_d;
      last_q        <= last_d;
      issue_idx_q   <= issue_idx_d;
      emit_idx_q    <= emit_idx_d;
      credits_q     <= credits_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      edges_empty_q <= edges_empty_d;
      err_q         <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible through fifo_cnt_q.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {mem_resp_dst_id, mem_resp_edge_data};
  end

  assign head = fifo_mem[rd_ptr_q];

  assign mem_req_addr    = base_q + (issue_idx_q * 64'(EDGE_BYTES));

  assign out_valid       = (fifo_cnt_q != '0);
  assign out_vertex_id   = out_valid ? vid_q       : 64'd0;
  assign out_edge_id     = out_valid ? emit_idx_q  : 64'd0;
  assign out_dst_id      = out_valid ? head[127:64] : 64'd0;
  assign out_edge_data   = out_valid ? head[63:0]  : 64'd0;
  assign out_last_edge   = out_valid & last_emit;
  assign out_last_vertex = out_last_edge & last_q;

  assign edges_empty     = edges_empty_q;
  assign busy            = (state_q != IDLE) | (fifo_cnt_q != '0);
  assign err             = err_q;

endmodule

// File: tb/tb_edge_fetch_sequencer.sv
// Bench for edge_fetch_sequencer: directed scenarios plus randomized vertices,
// checked every cycle against a queue-based model of the expected requests/tokens.
module tb_edge_fetch_sequencer;

  localparam int EB = 16;
  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vtx_valid = 1'b0;
  logic        vtx_ready;
  logic [63:0] vtx_id = 64'd0;
  logic [63:0] vtx_edge_addr = 64'd0;
  logic [63:0] vtx_num_edges = 64'd0;
  logic        vtx_last = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_edge_data = 64'd0;
  logic [63:0] mem_resp_dst_id = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_vertex_id;
  logic [63:0] out_edge_id;
  logic [63:0] out_dst_id;
  logic [63:0] out_edge_data;
  logic        out_last_edge;
  logic        out_last_vertex;
  logic        edges_empty;
  logic        busy;
  logic        err;

  edge_fetch_sequencer #(.EDGE_BYTES(EB), .MAX_OUTSTANDING(MO)) dut (
    .clk                (clk),
    .reset              (reset),
    .vtx_valid          (vtx_valid),
    .vtx_ready          (vtx_ready),
    .vtx_id             (vtx_id),
    .vtx_edge_addr      (vtx_edge_addr),
    .vtx_num_edges      (vtx_num_edges),
    .vtx_last           (vtx_last),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_edge_data (mem_resp_edge_data),
    .mem_resp_dst_id    (mem_resp_dst_id),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_vertex_id      (out_vertex_id),
    .out_edge_id        (out_edge_id),
    .out_dst_id         (out_dst_id),
    .out_edge_data      (out_edge_data),
    .out_last_edge      (out_last_edge),
    .out_last_vertex    (out_last_vertex),
    .edges_empty        (edges_empty),
    .busy               (busy),
    .err                (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] vid;
    logic [63:0] eid;
    logic [63:0] dst;
    logic [63:0] data;
    logic        le;
    logic        lv;
  } tok_t;

  tok_t        expTokQ[$];
  logic [63:0] expReqQ[$];
  logic [63:0] memPendQ[$];

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int popped = 0;
  int delivered = 0;
  int reqTotal = 0;
  int dutEmptyPulses = 0;
  logic errExp = 1'b0;
  logic expEmpty = 1'b0;

  int reqReadyPct = 100;
  int respPct = 100;
  int outReadyPct = 100;
  bit holdOutLow = 1'b0;
  bit injectSpurious = 1'b0;
  bit respSpurious = 1'b0;

  function automatic logic [63:0] dstOf(input logic [63:0] a);
    return a ^ 64'hA5A5_0000_5A5A_FFFF;
  endfunction

  function automatic logic [63:0] dataOf(input logic [63:0] a);
    return {a[31:0], ~a[63:32]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Memory and downstream model: random readiness, in-order responses with random latency.
  always @(posedge clk) begin : driver
    logic [63:0] a;
    #1;
    mem_req_ready      = (int'($urandom_range(99)) < reqReadyPct);
    out_ready          = !holdOutLow && (int'($urandom_range(99)) < outReadyPct);
    mem_resp_valid     = 1'b0;
    respSpurious       = 1'b0;
    mem_resp_dst_id    = {$urandom, $urandom};
    mem_resp_edge_data = {$urandom, $urandom};
    if (!reset) begin
      memPendQ.delete();
    end else if (injectSpurious) begin
      mem_resp_valid = 1'b1;
      respSpurious   = 1'b1;
      injectSpurious = 1'b0;
    end else if (memPendQ.size() > 0 && int'($urandom_range(99)) < respPct) begin
      a                  = memPendQ.pop_front();
      mem_resp_valid     = 1'b1;
      mem_resp_dst_id    = dstOf(a);
      mem_resp_edge_data = dataOf(a);
    end
  end

  // Reference model: each check uses the model state before this cycle's handshakes.
  always @(negedge clk) begin : monitor
    bit          readyExp;
    tok_t        t;
    logic [63:0] a;
    if (!reset) begin
      expTokQ.delete();
      expReqQ.delete();
      issued    = 0;
      popped    = 0;
      delivered = 0;
      errExp    = 1'b0;
      expEmpty  = 1'b0;
    end else begin
      readyExp = (expTokQ.size() == 0);
      checkOutput("vtx_ready", 64'(vtx_ready), 64'(readyExp));
      checkOutput("busy", 64'(busy), 64'(expTokQ.size() != 0));
      checkOutput("req_valid", 64'(mem_req_valid), 64'(expReqQ.size() != 0 && (issued - popped) < MO));
      checkOutput("out_valid", 64'(out_valid), 64'((delivered - popped) > 0));
      checkOutput("edges_empty", 64'(edges_empty), 64'(expEmpty));
      checkOutput("err", 64'(err), 64'(errExp));
      if (mem_req_valid && expReqQ.size() > 0)
        checkOutput("req_addr", mem_req_addr, expReqQ[0]);
      if (out_valid && expTokQ.size() > 0) begin
        t = expTokQ[0];
        checkOutput("tok_vertex", out_vertex_id, t.vid);
        checkOutput("tok_edge_id", out_edge_id, t.eid);
        checkOutput("tok_dst", out_dst_id, t.dst);
        checkOutput("tok_data", out_edge_data, t.data);
        checkOutput("tok_flags", 64'({out_last_edge, out_last_vertex}), 64'({t.le, t.lv}));
      end
      if (mem_req_valid && mem_req_ready) begin
        if (expReqQ.size() > 0) void'(expReqQ.pop_front());
        memPendQ.push_back(mem_req_addr);
        issued++;
        reqTotal++;
      end
      if (out_valid && out_ready) begin
        if (expTokQ.size() > 0) void'(expTokQ.pop_front());
        popped++;
      end
      if (mem_resp_valid) begin
        if (respSpurious) errExp = 1'b1;
        else delivered++;
      end
      if (edges_empty) dutEmptyPulses++;
      expEmpty = vtx_valid && readyExp && (vtx_num_edges == 64'd0);
      if (vtx_valid && readyExp && vtx_num_edges != 64'd0) begin
        for (int e = 0; e < int'(vtx_num_edges); e++) begin
          a      = vtx_edge_addr + 64'(e) * 64'(EB);
          expReqQ.push_back(a);
          t.vid  = vtx_id;
          t.eid  = 64'(e);
          t.dst  = dstOf(a);
          t.data = dataOf(a);
          t.le   = (e == int'(vtx_num_edges) - 1);
          t.lv   = t.le && vtx_last;
          expTokQ.push_back(t);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] id, input logic [63:0] addr,
                               input logic [63:0] n, input logic last);
    @(posedge clk);
    #1;
    vtx_id        = id;
    vtx_edge_addr = addr;
    vtx_num_edges = n;
    vtx_last      = last;
    vtx_valid     = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (vtx_ready) break;
    end
    checkOutput("vtx_accept", 64'(vtx_ready), 64'd1);
    @(posedge clk);
    #1;
    vtx_valid = 1'b0;
  endtask

  task automatic waitForDrain();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #2;
      if (expTokQ.size() == 0 && expReqQ.size() == 0) break;
    end
    @(negedge clk);
    #1;
    checkOutput("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int base;

    // Reset state
    @(posedge clk);
    #1;
    checkOutput("rst_flags", 64'({vtx_ready, mem_req_valid, out_valid, out_last_edge,
                                  out_last_vertex, edges_empty, busy, err}), 64'd0);
    checkOutput("rst_req_addr", mem_req_addr, 64'd0);
    checkOutput("rst_out_vid", out_vertex_id, 64'd0);
    checkOutput("rst_out_dst", out_dst_id | out_edge_data | out_edge_id, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post_rst_ready", 64'(vtx_ready), 64'd1);

    $display("[TB] single vertex, 3 edges");
    applyStimulus(64'd7, 64'h1000, 64'd3, 1'b0);
    waitForDrain();

    $display("[TB] zero-edge vertex");
    base = reqTotal;
    applyStimulus(64'd9, 64'h2000, 64'd0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("empty_pulses", 64'(dutEmptyPulses), 64'd1);
    checkOutput("zero_no_req", 64'(reqTotal - base), 64'd0);
    checkOutput("zero_no_tok", 64'(out_valid), 64'd0);

    $display("[TB] credit stall, 10 edges");
    holdOutLow = 1'b1;
    base = reqTotal;
    applyStimulus(64'd11, 64'h4000, 64'd10, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("stall_reqs", 64'(reqTotal - base), 64'd4);
    checkOutput("stall_req_valid", 64'(mem_req_valid), 64'd0);
    holdOutLow = 1'b0;
    waitForDrain();
    checkOutput("stall_total", 64'(reqTotal - base), 64'd10);

    $display("[TB] back-to-back vertices");
    applyStimulus(64'hA, 64'h8000, 64'd2, 1'b0);
    applyStimulus(64'hB, 64'h9000, 64'd1, 1'b1);
    waitForDrain();

    $display("[TB] address wrap");
    applyStimulus(64'd21, 64'hFFFF_FFFF_FFFF_FFE0, 64'd4, 1'b1);
    waitForDrain();

    $display("[TB] spurious response");
    injectSpurious = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("spur_err", 64'(err), 64'd1);
    checkOutput("spur_no_tok", 64'(out_valid), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("spur_err_held", 64'(err), 64'd1);

    $display("[TB] reset mid-issue");
    respPct = 0;
    base = reqTotal;
    applyStimulus(64'd33, 64'hC000, 64'd5, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (reqTotal - base >= 2) break;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_reqs", 64'(reqTotal - base), 64'd2);
    checkOutput("mid_rst_flags", 64'({vtx_ready, mem_req_valid, out_valid, out_last_edge,
                                      out_last_vertex, edges_empty, busy, err}), 64'd0);
    checkOutput("mid_rst_addr", mem_req_addr, 64'd0);
    checkOutput("mid_rst_fields", out_vertex_id | out_edge_id | out_dst_id | out_edge_data, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    respPct = 100;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rel_ready", 64'(vtx_ready), 64'd1);
    checkOutput("rel_busy", 64'(busy), 64'd0);
    checkOutput("rel_err", 64'(err), 64'd0);

    $display("[TB] randomized vertices");
    for (int i = 0; i < 40; i++) begin
      logic [63:0] addr;
      logic [63:0] n;
      reqReadyPct = int'($urandom_range(30, 100));
      respPct     = int'($urandom_range(30, 100));
      outReadyPct = int'($urandom_range(30, 100));
      addr = (i % 8 == 7) ? 64'hFFFF_FFFF_FFFF_FFD0 : {$urandom, $urandom};
      n    = ($urandom_range(4) == 0) ? 64'd0 : 64'($urandom_range(1, 12));
      applyStimulus({$urandom, $urandom}, addr, n, 1'($urandom_range(1)));
      if ($urandom_range(3) != 0) waitForDrain();
    end
    waitForDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
